// File: rtl/tankb_io_pkg.sv
// Shared constants and types for the Tank Battalion I/O port responder.
package tankb_io_pkg;

    localparam int unsigned IO_W             = 8;
    localparam int unsigned COIN1_BIT        = 0;
    localparam int unsigned COIN2_BIT        = 1;
    localparam logic [7:0]  IO_IDLE          = 8'hFF;
    localparam int unsigned DEBOUNCE_SAMPLES = 4;
    localparam int unsigned DB_CNT_W         = $clog2(DEBOUNCE_SAMPLES);
    localparam int unsigned PRESCALE_W       = 16;
    localparam int unsigned WDT_CNT_W        = 8;
    localparam int unsigned WDT_PULSE_W      = 4;

    typedef logic [IO_W-1:0] io_byte_t;

endpackage

// File: rtl/tankb_io_ports_if.sv
// CPU-side decode strobes, write data and read data between the bus and the I/O responder.
interface tankb_io_ports_if;
    import tankb_io_pkg::*;

    logic     cpu_clken;
    logic [2:0] addr;
    io_byte_t dbo;
    logic     n_in0;
    logic     n_in1;
    logic     n_dipsw;
    logic     n_out0;
    logic     n_out1;
    logic     n_wdr;
    io_byte_t dbi;

    modport master (
        output cpu_clken, addr, dbo, n_in0, n_in1, n_dipsw, n_out0, n_out1, n_wdr,
        input  dbi
    );

    modport slave (
        input  cpu_clken, addr, dbo, n_in0, n_in1, n_dipsw, n_out0, n_out1, n_wdr,
        output dbi
    );

endinterface

// File: rtl/tankb_debounce.sv
// Two-flop synchronizer plus per-bit stability counter; a bit flips only after
// DEBOUNCE_SAMPLES consecutive ticks disagreeing with its current value.
module tankb_debounce
    import tankb_io_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_db
);

    logic [WIDTH-1:0]    r_sync1;
    logic [WIDTH-1:0]    r_sync2;
    logic [WIDTH-1:0]    r_db;
    logic [DB_CNT_W-1:0] r_cnt [WIDTH];

    // Sync flops start idle-high so reset release never looks like a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db <= '1;
            for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
        end else if (i_tick) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_cnt[i] == DB_CNT_W'(DEBOUNCE_SAMPLES - 1)) begin
                        r_db[i]  <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/tankb_io_ports.sv
// CPU-side responder for the IN0/IN1/DIPSW reads, OUT0/OUT1 addressable latches
// and the nWDR watchdog.
module tankb_io_ports
    import tankb_io_pkg::*;
#(
    parameter logic [PRESCALE_W-1:0]  DEBOUNCE_TICK = 16'd50000,
    parameter logic [WDT_CNT_W-1:0]   WDT_FRAMES    = 8'd16,
    parameter logic [WDT_PULSE_W-1:0] WDT_PULSE     = 4'd8
) (
    input  logic             clk,
    input  logic             rst,
    tankb_io_ports_if.slave  bus,
    input  logic             vblank,
    input  io_byte_t         in0_raw,
    input  io_byte_t         in1_raw,
    input  io_byte_t         dip,
    output io_byte_t         out0,
    output io_byte_t         out1,
    output logic             wdt_reset
);

    logic [PRESCALE_W-1:0]  r_presc;
    logic                   w_tick;
    logic [2*IO_W-1:0]      w_db;
    io_byte_t               w_db_in0;
    io_byte_t               w_db_in1;
    logic [1:0]             w_coin_now;
    logic [1:0]             r_coin_prev;
    logic [1:0]             w_coin_fall;
    logic [1:0]             r_coin_flag;
    logic                   w_in0_clr;
    io_byte_t               w_in0;
    io_byte_t               w_dbi;
    io_byte_t               r_out0;
    io_byte_t               r_out1;
    logic                   r_vblank_d;
    logic                   w_vb_rise;
    logic                   w_wdr_clr;
    logic                   w_wdt_fire;
    logic [WDT_CNT_W-1:0]   r_wdt_cnt;
    logic [WDT_PULSE_W-1:0] r_pulse_cnt;
    logic                   r_wdt_reset;

    // Shared debounce sample prescaler
    assign w_tick = (r_presc == DEBOUNCE_TICK - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    tankb_debounce #(.WIDTH(2 * IO_W)) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .i_tick (w_tick),
        .i_raw  ({in1_raw, in0_raw}),
        .o_db   (w_db)
    );

    assign w_db_in0 = w_db[IO_W-1:0];
    assign w_db_in1 = w_db[2*IO_W-1:IO_W];

    // Sticky coin flags: set on debounced falling edge, cleared by an IN0 read; set wins
    assign w_coin_now  = {w_db_in0[COIN2_BIT], w_db_in0[COIN1_BIT]};
    assign w_coin_fall = r_coin_prev & ~w_coin_now;
    assign w_in0_clr   = bus.cpu_clken & ~bus.n_in0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coin_prev <= 2'b11;
            r_coin_flag <= 2'b00;
        end else begin
            r_coin_prev <= w_coin_now;
            r_coin_flag <= w_coin_fall | (r_coin_flag & ~{2{w_in0_clr}});
        end
    end

    always_comb begin
        w_in0            = w_db_in0;
        w_in0[COIN1_BIT] = ~r_coin_flag[0];
        w_in0[COIN2_BIT] = ~r_coin_flag[1];
    end

    always_comb begin
        w_dbi = IO_IDLE;
        if (!bus.n_in0)        w_dbi = w_in0;
        else if (!bus.n_in1)   w_dbi = w_db_in1;
        else if (!bus.n_dipsw) w_dbi = dip;
    end

    assign bus.dbi = w_dbi;

    // 74LS259-style addressable latches, only dbo[0] is stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out0 <= '0;
            r_out1 <= '0;
        end else if (bus.cpu_clken) begin
            if (!bus.n_out0) r_out0[bus.addr] <= bus.dbo[0];
            if (!bus.n_out1) r_out1[bus.addr] <= bus.dbo[0];
        end
    end

    assign out0 = r_out0;
    assign out1 = r_out1;

    // Watchdog: counts vblank rises, an nWDR write clears and beats a same-cycle rise
    assign w_vb_rise  = vblank & ~r_vblank_d;
    assign w_wdr_clr  = bus.cpu_clken & ~bus.n_wdr;
    assign w_wdt_fire = w_vb_rise & ~w_wdr_clr & (r_wdt_cnt == WDT_FRAMES - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vblank_d <= 1'b0;
            r_wdt_cnt  <= '0;
        end else begin
            r_vblank_d <= vblank;
            if (w_wdr_clr)       r_wdt_cnt <= '0;
            else if (w_wdt_fire) r_wdt_cnt <= '0;
            else if (w_vb_rise)  r_wdt_cnt <= r_wdt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdt_reset <= 1'b0;
            r_pulse_cnt <= '0;
        end else if (w_wdt_fire) begin
            r_wdt_reset <= 1'b1;
            r_pulse_cnt <= WDT_PULSE - 1'b1;
        end else if (r_wdt_reset) begin
            if (r_pulse_cnt == '0) r_wdt_reset <= 1'b0;
            else                   r_pulse_cnt <= r_pulse_cnt - 1'b1;
        end
    end

    assign wdt_reset = r_wdt_reset;

endmodule

// File: tb/tb_tankb_io_ports.sv
// Scoreboard bench for tankb_io_ports: reads, coin latch, OUT latches, watchdog, async reset.
module tb_tankb_io_ports;
    import tankb_io_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     vblank;
    io_byte_t in0_raw;
    io_byte_t in1_raw;
    io_byte_t dip;
    io_byte_t out0;
    io_byte_t out1;
    logic     wdt_reset;

    tankb_io_ports_if bus();

    tankb_io_ports #(
        .DEBOUNCE_TICK (16'd4),
        .WDT_FRAMES    (8'd4),
        .WDT_PULSE     (4'd8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .vblank    (vblank),
        .in0_raw   (in0_raw),
        .in1_raw   (in1_raw),
        .dip       (dip),
        .out0      (out0),
        .out1      (out1),
        .wdt_reset (wdt_reset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int wdt_hi   = 0;

    string     sb_tag [$];
    logic [7:0] sb_exp [$];

    io_byte_t m_out0 = 8'h00;
    io_byte_t m_out1 = 8'h00;

    always @(negedge clk) if (wdt_reset === 1'b1) wdt_hi++;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [7:0] exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
    endtask

    task automatic sb_pop_check(input logic [7:0] got);
        if (sb_exp.size() == 0) begin
            check_val("sb_empty", 8'(sb_exp.size()), 8'd1);
        end else begin
            check_val(sb_tag.pop_front(), got, sb_exp.pop_front());
        end
    endtask

    function automatic logic [7:0] probe(input int sel);
        case (sel)
            0:       return bus.dbi;
            1:       return out0;
            2:       return out1;
            default: return {7'b0, wdt_reset};
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Samples one observable at the next falling edge; returns at posedge+1
    task automatic probe_chk(input string tag, input int sel, input logic [7:0] exp);
        sb_push(tag, exp);
        @(negedge clk);
        sb_pop_check(probe(sel));
        cyc(1);
    endtask

    // mask bits: [0]=n_in0, [1]=n_in1, [2]=n_dipsw asserted
    task automatic rd(input logic [2:0] mask, input logic en, input string tag, input logic [7:0] exp);
        bus.n_in0     = ~mask[0];
        bus.n_in1     = ~mask[1];
        bus.n_dipsw   = ~mask[2];
        bus.cpu_clken = en;
        sb_push(tag, exp);
        @(negedge clk);
        sb_pop_check(bus.dbi);
        cyc(1);
        bus.n_in0 = 1'b1; bus.n_in1 = 1'b1; bus.n_dipsw = 1'b1;
        bus.cpu_clken = 1'b0;
    endtask

    task automatic wr(input logic o0, input logic o1, input logic [2:0] a,
                      input logic [7:0] d, input logic en, input string tag);
        bus.n_out0 = ~o0; bus.n_out1 = ~o1;
        bus.addr = a; bus.dbo = d; bus.cpu_clken = en;
        cyc(1);
        bus.n_out0 = 1'b1; bus.n_out1 = 1'b1; bus.cpu_clken = 1'b0;
        if (en && o0) m_out0[a] = d[0];
        if (en && o1) m_out1[a] = d[0];
        probe_chk({tag, "_out0"}, 1, m_out0);
        probe_chk({tag, "_out1"}, 2, m_out1);
    endtask

    task automatic vb_edges(input int n);
        repeat (n) begin
            vblank = 1'b1; cyc(3);
            vblank = 1'b0; cyc(3);
        end
    endtask

    task automatic wdr_write();
        bus.n_wdr = 1'b0; bus.cpu_clken = 1'b1;
        cyc(1);
        bus.n_wdr = 1'b1; bus.cpu_clken = 1'b0;
    endtask

    initial begin
        int zeros;
        rst = 1'b1; vblank = 1'b0;
        in0_raw = 8'hFF; in1_raw = 8'hFF; dip = 8'hA5;
        bus.cpu_clken = 1'b0; bus.addr = 3'd0; bus.dbo = 8'h00;
        bus.n_in0 = 1'b1; bus.n_in1 = 1'b1; bus.n_dipsw = 1'b1;
        bus.n_out0 = 1'b1; bus.n_out1 = 1'b1; bus.n_wdr = 1'b1;
        cyc(3);
        probe_chk("rst_dbi", 0, 8'hFF);
        probe_chk("rst_out0", 1, 8'h00);
        probe_chk("rst_out1", 2, 8'h00);
        probe_chk("rst_wdt", 3, 8'h00);
        rst = 1'b0;
        cyc(2);

        // Debounce: short glitch rejected, long hold accepted and released
        in1_raw[3] = 1'b0; cyc(8); in1_raw[3] = 1'b1; cyc(30);
        rd(3'b010, 1'b1, "db_glitch", 8'hFF);
        in1_raw[3] = 1'b0; cyc(24);
        rd(3'b010, 1'b1, "db_hold", 8'hF7);
        in1_raw[3] = 1'b1; cyc(30);
        rd(3'b010, 1'b1, "db_release", 8'hFF);

        // Read mux priority
        in1_raw[6] = 1'b0; cyc(30);
        rd(3'b110, 1'b1, "prio_in1_dip", 8'hBF);
        rd(3'b100, 1'b0, "dip_read", 8'hA5);
        rd(3'b000, 1'b0, "no_strobe", 8'hFF);
        rd(3'b101, 1'b0, "prio_in0_dip", 8'hFF);

        // Coin latch: sticky until a qualified IN0 read
        in0_raw[0] = 1'b0; cyc(24); in0_raw[0] = 1'b1; cyc(30);
        rd(3'b001, 1'b0, "coin_noclken", 8'hFE);
        rd(3'b001, 1'b1, "coin1_rd", 8'hFE);
        rd(3'b001, 1'b1, "coin1_cleared", 8'hFF);
        in0_raw[7] = 1'b0; cyc(30);
        rd(3'b001, 1'b1, "in0_upper", 8'h7F);
        in0_raw[7] = 1'b1; cyc(30);

        // Coin edge while IN0 is read every cycle: flag must be seen exactly once
        bus.n_in0 = 1'b0; bus.cpu_clken = 1'b1;
        zeros = 0;
        in0_raw[1] = 1'b0;
        sb_push("coin_vs_read", 8'd1);
        repeat (40) begin
            @(negedge clk);
            if (bus.dbi[1] == 1'b0) zeros++;
        end
        sb_pop_check(8'(zeros));
        cyc(1);
        bus.n_in0 = 1'b1; bus.cpu_clken = 1'b0;
        in0_raw[1] = 1'b1; cyc(30);
        rd(3'b001, 1'b1, "coin2_idle", 8'hFF);

        // OUT latches
        wr(1'b1, 1'b0, 3'd5, 8'h01, 1'b1, "l_set5");
        wr(1'b1, 1'b0, 3'd5, 8'h00, 1'b1, "l_clr5");
        wr(1'b1, 1'b0, 3'd3, 8'h01, 1'b0, "l_noen");
        wr(1'b1, 1'b1, 3'd2, 8'hFF, 1'b1, "l_both");
        wr(1'b0, 1'b1, 3'd7, 8'h01, 1'b1, "l_out1_7");
        wr(1'b0, 1'b1, 3'd2, 8'hFE, 1'b1, "l_bit0only");
        check_val("l_const0", out0, 8'h04);
        check_val("l_const1", out1, 8'h80);

        // Watchdog
        wdt_hi = 0; vb_edges(4); cyc(12);
        check_val("wdt_pulse_len", 8'(wdt_hi), 8'd8);
        wdt_hi = 0; vb_edges(3); wdr_write(); vb_edges(3); cyc(12);
        check_val("wdt_fed", 8'(wdt_hi), 8'd0);
        vb_edges(1); cyc(12);
        check_val("wdt_after_feed", 8'(wdt_hi), 8'd8);

        // Async reset in the middle of a pulse
        vb_edges(3);
        vblank = 1'b1; cyc(3);
        probe_chk("wdt_mid", 3, 8'h01);
        #2 rst = 1'b1; vblank = 1'b0;
        #1 sb_push("wdt_async", 8'h00);
        sb_pop_check({7'b0, wdt_reset});
        cyc(2);
        probe_chk("rst2_out0", 1, 8'h00);
        probe_chk("rst2_dbi", 0, 8'hFF);
        rst = 1'b0; m_out0 = 8'h00; m_out1 = 8'h00;
        cyc(2);
        wdt_hi = 0; vb_edges(3); cyc(12);
        check_val("wdt_restart3", 8'(wdt_hi), 8'd0);
        vb_edges(1); cyc(12);
        check_val("wdt_restart4", 8'(wdt_hi), 8'd8);

        check_val("sb_drain", 8'(sb_exp.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
